// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer: state encoding,
// default geometry/latencies and the index-width derivation.
package matmul_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_B,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } seq_state_t;

   localparam int DEFAULT_N            = 64;
   localparam int DEFAULT_ROM_LATENCY  = 2;
   localparam int DEFAULT_TREE_LATENCY = 0;

   // Index width for an N-entry address space; N is a power of two >= 2.
   function automatic int idxWidth(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Fixed-depth shift register carrying a valid bit plus an index payload.
// Depth 0 is a straight wire; i_clear synchronously empties the line.
module valid_delay_line #(
   parameter int DEPTH = 1,
   parameter int W     = 1
) (
   input  logic         clock,
   input  logic         i_clear,
   input  logic         i_valid,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   generate
      if (DEPTH == 0) begin : g_wire
         logic w_unused;
         assign w_unused = clock ^ i_clear;
         assign o_valid  = i_valid;
         assign o_data   = i_data;
      end else begin : g_pipe
         logic [DEPTH-1:0] r_valid;
         logic [W-1:0]     r_data [DEPTH];

         always_ff @(posedge clock) begin
            if (i_clear) begin
               r_valid <= '0;
               for (int i = 0; i < DEPTH; i++) begin
                  r_data[i] <= '0;
               end
            end else begin
               r_valid[0] <= i_valid;
               r_data[0]  <= i_data;
               for (int i = 1; i < DEPTH; i++) begin
                  r_valid[i] <= r_valid[i-1];
                  r_data[i]  <= r_data[i-1];
               end
            end
         end

         assign o_valid = r_valid[DEPTH-1];
         assign o_data  = r_data[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/matmul_sequencer.sv
// Control sequencer for an N x N matrix-vector product: streams B into the
// register bank, then issues A rows and aligns accumulate strobes to the tree.
module matmul_sequencer
   import matmul_pkg::*;
#(
   parameter  int N            = DEFAULT_N,
   parameter  int ROM_LATENCY  = DEFAULT_ROM_LATENCY,
   parameter  int TREE_LATENCY = DEFAULT_TREE_LATENCY,
   localparam int IDX_W        = idxWidth(N)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] rom_b_addr,
   output logic             b_wr_en,
   output logic [IDX_W-1:0] b_wr_idx,
   output logic [IDX_W-1:0] rom_a_row,
   output logic             acc_clear,
   output logic             acc_en,
   output logic [IDX_W-1:0] acc_idx,
   output logic [15:0]      cycle_count
);

   localparam int               L        = ROM_LATENCY + TREE_LATENCY;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   seq_state_t       r_state;
   seq_state_t       w_nextState;
   logic [IDX_W-1:0] r_bAddr;
   logic [IDX_W-1:0] r_aRow;
   logic [15:0]      r_drainCnt;
   logic [15:0]      r_cycleCount;
   logic             r_accClear;
   logic             w_accept;
   logic             w_busy;
   logic             w_lastB;
   logic             w_lastA;
   logic             w_lastDrain;
   logic             w_bIssue;
   logic             w_aIssue;

   assign w_lastB     = (r_bAddr == LAST_IDX);
   assign w_lastA     = (r_aRow == LAST_IDX);
   assign w_lastDrain = (r_drainCnt == 16'(L - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      w_busy      = 1'b0;
      w_bIssue    = 1'b0;
      w_aIssue    = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_nextState = ST_LOAD_B;
            end
         end
         ST_LOAD_B: begin
            w_busy   = 1'b1;
            w_bIssue = 1'b1;
            if (w_lastB) w_nextState = ST_RUN;
         end
         ST_RUN: begin
            w_busy   = 1'b1;
            w_aIssue = 1'b1;
            if (w_lastA) w_nextState = (L == 0) ? ST_DONE : ST_DRAIN;
         end
         ST_DRAIN: begin
            w_busy = 1'b1;
            if (w_lastDrain) w_nextState = ST_DONE;
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               w_accept    = 1'b1;
               w_nextState = ST_LOAD_B;
            end
         end
         default: w_nextState = ST_IDLE;
      endcase
   end

   // Counters never wrap inside a run; the A row restarts on the last B beat.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_bAddr      <= '0;
         r_aRow       <= '0;
         r_drainCnt   <= '0;
         r_cycleCount <= '0;
         r_accClear   <= 1'b0;
      end else begin
         r_accClear <= w_accept;

         if (w_accept) begin
            r_bAddr <= '0;
         end else if (r_state == ST_LOAD_B && !w_lastB) begin
            r_bAddr <= r_bAddr + IDX_W'(1);
         end

         if (r_state == ST_LOAD_B && w_lastB) begin
            r_aRow <= '0;
         end else if (r_state == ST_RUN && !w_lastA) begin
            r_aRow <= r_aRow + IDX_W'(1);
         end

         if (r_state == ST_RUN) begin
            r_drainCnt <= '0;
         end else if (r_state == ST_DRAIN) begin
            r_drainCnt <= r_drainCnt + 16'd1;
         end

         if (w_accept) begin
            r_cycleCount <= '0;
         end else if (w_busy && r_cycleCount != 16'hFFFF) begin
            r_cycleCount <= r_cycleCount + 16'd1;
         end
      end
   end

   valid_delay_line #(
      .DEPTH (ROM_LATENCY),
      .W     (IDX_W)
   ) u_bWrDelay (
      .clock   (clock),
      .i_clear (reset),
      .i_valid (w_bIssue),
      .i_data  (r_bAddr),
      .o_valid (b_wr_en),
      .o_data  (b_wr_idx)
   );

   valid_delay_line #(
      .DEPTH (L),
      .W     (IDX_W)
   ) u_accDelay (
      .clock   (clock),
      .i_clear (reset),
      .i_valid (w_aIssue),
      .i_data  (r_aRow),
      .o_valid (acc_en),
      .o_data  (acc_idx)
   );

   assign busy        = w_busy;
   assign rom_b_addr  = r_bAddr;
   assign rom_a_row   = r_aRow;
   assign acc_clear   = r_accClear;
   assign cycle_count = r_cycleCount;

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameter N, default 64, meaning matrix dimension (rows of A, length of B); power of two, 2..64.
REQ-002 Parameter ROM_LATENCY, default 2, meaning cycles from ROM address to ROM data.
REQ-003 Parameter TREE_LATENCY, default 0, meaning pipeline stages in multiplier/adder tree.
REQ-004 clock  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  request a new A*B computation.
REQ-007 busy  out  1  high in LOAD_B, RUN, DRAIN.
REQ-008 done  out  1  high in DONE.
REQ-009 rom_b_addr  out  IDX_W  B ROM element address; IDX_W = log2(N).
REQ-010 b_wr_en  out  1  B register bank write strobe.
REQ-011 b_wr_idx  out  IDX_W  B register bank write index.
REQ-012 rom_a_row  out  IDX_W  A ROM row address (wide ROM returns N elements).
REQ-013 acc_clear  out  1  clear result accumulator.
REQ-014 acc_en  out  1  accumulate tree output into result accumulator.
REQ-015 acc_idx  out  IDX_W  row index of tree output being accumulated.
REQ-016 cycle_count  out  16  busy cycles of last/current run.

Function
REQ-017 States IDLE, LOAD_B, RUN, DRAIN, DONE; L = ROM_LATENCY + TREE_LATENCY.
REQ-018 start accepted only in IDLE or DONE; start in LOAD_B/RUN/DRAIN ignored, no effect.
REQ-019 Accept at cycle T -> LOAD_B at T+1; acc_clear high exactly at T+1; cycle_count = 0 at T+1.
REQ-020 LOAD_B: N cycles, rom_b_addr = 0..N-1 consecutively, then RUN.
REQ-021 b_wr_en/b_wr_idx = LOAD_B address issue delayed exactly ROM_LATENCY cycles.
REQ-022 RUN: N cycles, rom_a_row = 0..N-1 consecutively, starting cycle after last B address.
REQ-023 acc_en/acc_idx = RUN row issue delayed exactly L cycles; acc_idx = row issued.
REQ-024 After row N-1: DRAIN for L cycles (skipped when L = 0), then DONE.
REQ-025 DONE: done held high, addresses held, until start accepted (-> LOAD_B) or reset.
REQ-026 cycle_count increments by 1 each busy cycle, saturates at 16'hFFFF, held in IDLE/DONE.
REQ-027 Total busy cycles = 2N + L; N=64, L=2 -> cycle_count = 130 when done rises.
REQ-028 acc_clear and acc_en never high same cycle; b_wr_en never high after first acc_en of a run.
REQ-029 Address counters do not wrap within a run; outside LOAD_B/RUN they hold last value.

Reset
REQ-030 reset high at any edge, including mid-run -> next cycle state IDLE, all delay-line valids cleared.
REQ-031 Reset values: busy 0, done 0, b_wr_en 0, acc_en 0, acc_clear 0, all addresses/indices 0, cycle_count 0.
REQ-032 reset dominates start in the same cycle.

Structure
REQ-033 Package matmul_pkg holds state enum, default N, ROM_LATENCY, TREE_LATENCY, IDX_W derivation.
REQ-034 Sub-module valid_delay_line (depth parameter, valid + IDX_W payload, clearable) used for b_wr and acc paths.

Verification
REQ-035 Reset, start at T (N=64, L=2) -> acc_clear at T+1, rom_b_addr 0..63 over T+1..T+64, b_wr_en T+3..T+66.
REQ-036 Same run -> rom_a_row 0..63 over T+65..T+128, acc_en idx 0..63 over T+67..T+130, done at T+131, cycle_count 130.
REQ-037 start pulsed during RUN -> no change to sequence; start in DONE -> new run, done low next cycle, cycle_count restarts at 0.
REQ-038 reset asserted at T+70 -> IDLE at T+71, acc_en/b_wr_en low, no further acc_en pulses.
REQ-039 ROM_LATENCY=0, TREE_LATENCY=0, N=4 -> no DRAIN, done 9 cycles after accept, cycle_count 8.
REQ-040 reset and start high same cycle -> remains IDLE, busy 0.
